// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state encoding,
// instruction-class bit positions and the one-hot helper.
package ctrl_pkg;

    localparam int CODE_W = 10;

    // Bit positions inside the one-hot instruction-class code.
    localparam int CLS_J     = 0;
    localparam int CLS_JALR  = 1;
    localparam int CLS_LUI   = 2;
    localparam int CLS_AUIPC = 3;
    localparam int CLS_B     = 4;
    localparam int CLS_R     = 5;
    localparam int CLS_S     = 6;
    localparam int CLS_I     = 7;
    localparam int CLS_LOAD  = 8;
    localparam int CLS_CSR   = 9;

    // Encoding is visible on the debug port, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } state_t;

    // True when exactly one bit is set: clearing the lowest set bit leaves zero.
    function automatic logic is_one_hot(input logic [CODE_W-1:0] c);
        return (c != '0) && ((c & (c - CODE_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/ctrl_sel_decode.sv
// Combinational class decoder: turns the one-hot class into ALU operand
// selects and the per-class properties the sequencer branches on.
module ctrl_sel_decode
    import ctrl_pkg::*;
#(
    parameter int CSR_EN = 0
) (
    input  logic [CODE_W-1:0] cls,
    output logic              alu_sel_a,
    output logic              alu_sel_b,
    output logic              rd_we_class,
    output logic              is_mem,
    output logic              is_store,
    output logic              is_illegal
);

    // Operand A is the PC for jumps, AUIPC and branch target computation.
    assign alu_sel_a = cls[CLS_J] | cls[CLS_AUIPC] | cls[CLS_B];

    // Operand B is the immediate for every class that carries one into the ALU.
    assign alu_sel_b = cls[CLS_J] | cls[CLS_JALR] | cls[CLS_AUIPC]
                     | cls[CLS_S] | cls[CLS_I]    | cls[CLS_LOAD];

    // Classes that write rd; CSR only does so when the CSR mode is built in.
    assign rd_we_class = cls[CLS_J] | cls[CLS_JALR] | cls[CLS_LUI] | cls[CLS_AUIPC]
                       | cls[CLS_R] | cls[CLS_I]    | cls[CLS_LOAD]
                       | (cls[CLS_CSR] & (CSR_EN != 0));

    assign is_mem   = cls[CLS_S] | cls[CLS_LOAD];
    assign is_store = cls[CLS_S];

    // Anything that is not a single class, or CSR without CSR support, traps.
    assign is_illegal = !is_one_hot(cls) || (cls[CLS_CSR] && (CSR_EN == 0));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core. Steps each instruction
// through fetch, decode, execute, memory and writeback, drives the datapath
// selects/enables, and handles memory handshake timeout and illegal classes.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CSR_EN      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [CODE_W-1:0] code,
    input  logic              branch_taken,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              ir_load,
    output logic              alu_sel_a,
    output logic              alu_sel_b,
    output logic              rd_we,
    output logic              pc_load,
    output logic              pc_sel,
    output logic              retire,
    output logic              illegal,
    output logic              bus_error,
    output logic [2:0]        state_o
);

    // A zero limit still needs a one-bit counter to keep the code legal.
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    // The error fires in the wait cycle that would take the count to the limit.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t            state;
    state_t            state_next;
    logic [CODE_W-1:0] cls_q;
    logic [CODE_W-1:0] dec_cls;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              tmo_hit;

    logic dec_sel_a;
    logic dec_sel_b;
    logic dec_rd_we;
    logic dec_mem;
    logic dec_store;
    logic dec_illegal;

    // The trap decision in DECODE uses the live code; later states use the
    // latched class so the selects stay stable through MEM and WRITEBACK.
    assign dec_cls = (state == ST_DECODE) ? code : cls_q;

    ctrl_sel_decode #(
        .CSR_EN (CSR_EN)
    ) u_sel_decode (
        .cls         (dec_cls),
        .alu_sel_a   (dec_sel_a),
        .alu_sel_b   (dec_sel_b),
        .rd_we_class (dec_rd_we),
        .is_mem      (dec_mem),
        .is_store    (dec_store),
        .is_illegal  (dec_illegal)
    );

    // Limit reached with no acknowledge in this cycle; a late ack still wins.
    assign tmo_hit = (MEM_TIMEOUT != 0) && !mem_ready && (tmo_cnt == CNT_LAST);

    assign state_o = state;

    // State, latched class and wait counter; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state   <= ST_IDLE;
            cls_q   <= '0;
            tmo_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) begin
                cls_q <= code;
            end
            // Any state change (including MEM -> FETCH) starts a fresh request.
            if (state_next != state) begin
                tmo_cnt <= '0;
            end else if (mem_req && !mem_ready && (MEM_TIMEOUT != 0)) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and datapath controls, decoded from state, class and handshake.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_load    = 1'b0;
        alu_sel_a  = 1'b0;
        alu_sel_b  = 1'b0;
        rd_we      = 1'b0;
        pc_load    = 1'b0;
        pc_sel     = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        bus_error  = 1'b0;

        // While reset is held every strobe stays low so an abort writes nothing.
        if (reset) begin
            unique case (state)
                ST_IDLE: begin
                    if (run) state_next = ST_FETCH;
                end

                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_load    = 1'b1;
                        state_next = ST_DECODE;
                    end else if (tmo_hit) begin
                        bus_error  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end

                ST_DECODE: begin
                    state_next = dec_illegal ? ST_TRAP : ST_EXECUTE;
                end

                ST_EXECUTE: begin
                    alu_sel_a  = dec_sel_a;
                    alu_sel_b  = dec_sel_b;
                    state_next = dec_mem ? ST_MEM : ST_WRITEBACK;
                end

                ST_MEM: begin
                    alu_sel_a = dec_sel_a;
                    alu_sel_b = dec_sel_b;
                    mem_req   = 1'b1;
                    mem_we    = dec_store;
                    if (mem_ready) begin
                        if (dec_store) begin
                            // Stores complete here: next sequential PC, no rd write.
                            pc_load    = 1'b1;
                            retire     = 1'b1;
                            state_next = run ? ST_FETCH : ST_IDLE;
                        end else begin
                            state_next = ST_WRITEBACK;
                        end
                    end else if (tmo_hit) begin
                        bus_error  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end

                ST_WRITEBACK: begin
                    alu_sel_a  = dec_sel_a;
                    alu_sel_b  = dec_sel_b;
                    rd_we      = dec_rd_we;
                    pc_load    = 1'b1;
                    retire     = 1'b1;
                    pc_sel     = cls_q[CLS_J] | cls_q[CLS_JALR]
                               | (cls_q[CLS_B] & branch_taken);
                    state_next = run ? ST_FETCH : ST_IDLE;
                end

                ST_TRAP: begin
                    illegal    = 1'b1;
                    state_next = ST_IDLE;
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the RV32I core.
- Takes the 10-bit one-hot instruction-class code from the decoder and steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives datapath select and enable lines, including the ALU A/B operand selects, and replaces the purely combinational select gates.
- Adds memory handshake, timeout detection, illegal-class trapping and an optional CSR mode.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting for mem_ready per request; 0 disables the timeout.
- CSR_EN, 0: 1 = CSR class executes as a register-writing op; 0 = CSR class is illegal.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- run  in  1  allows leaving IDLE.
- code  in  10  one-hot class. Bit 0 J, 1 JALR, 2 LUI, 3 AUIPC, 4 B, 5 R, 6 S, 7 I-ALU, 8 LOAD, 9 CSR.
- branch_taken  in  1  branch comparator result, sampled in WRITEBACK.
- mem_ready  in  1  memory acknowledges the current request.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write strobe, qualifies mem_req.
- ir_load  out  1  instruction register load.
- alu_sel_a  out  1  1 = PC, 0 = rs1.
- alu_sel_b  out  1  1 = immediate, 0 = rs2.
- rd_we  out  1  register file write enable.
- pc_load  out  1  PC update enable.
- pc_sel  out  1  1 = ALU target, 0 = PC+4.
- retire  out  1  one-cycle pulse per completed instruction.
- illegal  out  1  one-cycle pulse on a bad class.
- bus_error  out  1  one-cycle pulse on memory timeout.
- state_o  out  3  current state, for debug.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, TRAP=6.
- Outputs are Moore: decoded from state, the latched class register cls_q and the live mem_ready (Mealy only for the load/ack strobes).
- Reset (reset=0 at a clock edge): state=IDLE, cls_q=0, timeout counter=0. All outputs are 0 while in IDLE. Reset mid-operation aborts immediately with no write strobes.
- IDLE: go to FETCH when run=1.
- FETCH:
  - mem_req=1, mem_we=0.
  - When mem_ready=1: ir_load=1 in that same cycle, then go to DECODE.
- DECODE:
  - cls_q <= code.
  - Go to TRAP if code is not exactly one-hot (zero or more than one bit set), or if code[9]=1 and CSR_EN=0. Otherwise go to EXECUTE.
- EXECUTE:
  - alu_sel_b=1 for J, JALR, AUIPC, S, I-ALU, LOAD; 0 for B, R, LUI, CSR. These values are decided; no don't-cares.
  - alu_sel_a=1 for J, AUIPC, B; 0 otherwise.
  - Go to MEM for S or LOAD; otherwise go to WRITEBACK.
- MEM:
  - mem_req=1, mem_we=cls_q[6].
  - On mem_ready, an S instruction completes here: pc_load=1, pc_sel=0, retire=1, then FETCH (or IDLE if run=0).
  - On mem_ready for LOAD: go to WRITEBACK.
- WRITEBACK:
  - rd_we=1 for every class except B.
  - pc_load=1 and retire=1.
  - pc_sel=1 for J or JALR, branch_taken for B, 0 otherwise.
  - Next state is FETCH if run=1, else IDLE.
- TRAP: illegal=1 for one cycle, no writes, no pc_load; go to IDLE.
- ALU operand selects stay stable through MEM and WRITEBACK. Selects are 0 in IDLE, FETCH, DECODE and TRAP.
- Timeout counter:
  - Width is clog2(MEM_TIMEOUT+1).
  - Clears on entering FETCH or MEM and increments each cycle mem_req=1 and mem_ready=0.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0: bus_error=1 for one cycle, mem_req drops, go to IDLE, no retire.
  - mem_ready arriving in the same cycle the limit is reached wins: no error.
- mem_ready outside FETCH and MEM is ignored.
- run is sampled only in IDLE and at instruction completion; an instruction in flight always finishes.

Decomposition:
- Shared package ctrl_pkg:
  - state localparams.
  - class bit indices (CLS_J=0 … CLS_CSR=9).
  - CODE_W=10.
- One sub-module, ctrl_sel_decode (combinational): cls_q -> alu_sel_a, alu_sel_b, rd_we_class, is_mem, is_store, is_illegal. It supersedes the standalone select gates.
- The FSM and timeout counter stay in the top module.

Test Plan:
- R-type, code=10'b0000100000, mem_ready tied 1, run=1 -> visits FETCH, DECODE, EXECUTE, WRITEBACK in 4 cycles. alu_sel_b=0 and alu_sel_a=0 in EXECUTE; rd_we=1, pc_load=1, retire=1 in WRITEBACK.
- LOAD, code=10'b0100000000, mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles with mem_we=0, then WRITEBACK with rd_we=1. Store, code=10'b0001000000 -> mem_we=1, retire in MEM, rd_we never asserted.
- Branch, code=10'b0000010000, branch_taken=1 then 0 -> alu_sel_b=0, alu_sel_a=1. pc_sel=1 then 0. rd_we=0 both times.
- Illegal: code=10'b0000000000, code=10'b0000110000, and code=10'b1000000000 with CSR_EN=0 -> illegal pulse for 1 cycle, then IDLE, no retire. Same CSR code with CSR_EN=1 -> rd_we=1, alu_sel_b=0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_error on the 4th wait cycle, then IDLE. Repeat with mem_ready=1 on the 4th cycle -> no error.
- Assert reset=0 during MEM -> at the next edge state=IDLE and all outputs 0. Release with run=1 -> FETCH one cycle later.
